miriscv_mem_arbiter: RTL and testbench

Shares a single data-memory port between the instruction-fetch requester and the LSU requester.
- Both upstream requesters use the core's hold-until-rvalid protocol: req, addr, we, be and wdata are held stable until rvalid.
- One transaction is outstanding at a time. The response is routed to the requester that owns the transaction.
- Sits between the fetch unit / LSU and the external memory bus at core top level.

---
 rtl/miriscv_mem_arb_pkg.sv | 25 ++
 rtl/miriscv_rr_arb2.sv | 44 ++++
 rtl/miriscv_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_miriscv_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miriscv_mem_arb_pkg.sv
//------------------------------------------------------------------------------
// Module  : miriscv_mem_arb_pkg
// Brief   : Shared types and constants for the fetch/LSU memory arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package miriscv_mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    ARB_OWNER_INSTR = 1'b0,
    ARB_OWNER_DATA  = 1'b1
  } arb_owner_e;

  // Sliced down to XLEN/8 at the point of use
  localparam logic [15:0] ARB_INSTR_BE = '1;

endpackage

`default_nettype wire

// File: rtl/miriscv_rr_arb2.sv
//------------------------------------------------------------------------------
// Module  : miriscv_rr_arb2
// Brief   : Two-input round-robin pick; last_grant advances only on update.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module miriscv_rr_arb2
  import miriscv_mem_arb_pkg::*;
(
  input  logic clk_i,
  input  logic arstn_i,
  input  logic req_instr_i,
  input  logic req_data_i,
  input  logic update_i,
  output logic grant_data_o
);

  arb_owner_e r_last_grant;
  arb_owner_e w_grant;

  always_comb begin
    w_grant = ARB_OWNER_DATA;
    if (req_instr_i && req_data_i) begin
      w_grant = (r_last_grant == ARB_OWNER_INSTR) ? ARB_OWNER_DATA : ARB_OWNER_INSTR;
    end else if (req_instr_i) begin
      w_grant = ARB_OWNER_INSTR;
    end
  end

  // Reset to INSTR so that DATA wins the first tie
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      r_last_grant <= ARB_OWNER_INSTR;
    end else if (update_i) begin
      r_last_grant <= w_grant;
    end
  end

  assign grant_data_o = (w_grant == ARB_OWNER_DATA);

endmodule

`default_nettype wire

// File: rtl/miriscv_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module  : miriscv_mem_arbiter
// Brief   : Shares one data-memory port between fetch and LSU, one transaction
//           outstanding. Optional watchdog: MIRISCV_MEM_ARB_TIMEOUT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module miriscv_mem_arbiter
  import miriscv_mem_arb_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              arstn_i,

  input  logic              instr_req_i,
  input  logic [XLEN-1:0]   instr_addr_i,
  output logic              instr_rvalid_o,
  output logic [XLEN-1:0]   instr_rdata_o,

  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [XLEN/8-1:0] data_be_i,
  input  logic [XLEN-1:0]   data_addr_i,
  input  logic [XLEN-1:0]   data_wdata_i,
  output logic              data_rvalid_o,
  output logic [XLEN-1:0]   data_rdata_o,

  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,

  output logic              arb_busy_o,
  output logic              arb_timeout_o
);

  arb_state_e r_state;
  arb_state_e w_state_next;
  arb_owner_e r_owner;
  arb_owner_e w_grant;
  logic       w_grant_data;
  logic       w_any_req;
  logic       w_start;
  logic       w_busy;
  logic       w_owner_req;
  logic       w_timeout;

  assign w_any_req   = instr_req_i | data_req_i;
  assign w_start     = (r_state == ARB_IDLE) && w_any_req;
  assign w_busy      = (r_state == ARB_BUSY);
  assign w_grant     = w_grant_data ? ARB_OWNER_DATA : ARB_OWNER_INSTR;
  assign w_owner_req = (r_owner == ARB_OWNER_DATA) ? data_req_i : instr_req_i;

  miriscv_rr_arb2 u_rr_arb2 (
    .clk_i        (clk_i),
    .arstn_i      (arstn_i),
    .req_instr_i  (instr_req_i),
    .req_data_i   (data_req_i),
    .update_i     (w_start),
    .grant_data_o (w_grant_data)
  );

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      r_state <= ARB_IDLE;
      r_owner <= ARB_OWNER_DATA;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_owner <= w_grant;
      end
    end
  end

`ifdef MIRISCV_MEM_ARB_TIMEOUT_EN
  localparam int c_wdog_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_wdog_w-1:0] r_wdog_cnt;

  always_ff @(posedge clk_i) begin
    if (!arstn_i || w_start) begin
      r_wdog_cnt <= '0;
    end else if (w_busy && !mem_rvalid_i) begin
      r_wdog_cnt <= r_wdog_cnt + 1'b1;
    end
  end

  // A real response in the same cycle takes precedence over expiry
  assign w_timeout = w_busy && !mem_rvalid_i &&
                     (r_wdog_cnt == c_wdog_w'(TIMEOUT_CYCLES - 1));
`else
  // Without the watchdog BUSY waits indefinitely; a negative limit has no meaning
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    w_state_next   = r_state;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_be_o       = '0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = '0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = '0;

    case (r_state)
      ARB_IDLE: begin
        if (w_any_req) begin
          w_state_next = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        mem_req_o = w_owner_req & ~mem_rvalid_i;
        if (r_owner == ARB_OWNER_DATA) begin
          mem_we_o    = data_we_i;
          mem_be_o    = data_be_i;
          mem_addr_o  = data_addr_i;
          mem_wdata_o = data_wdata_i;
        end else begin
          mem_be_o    = ARB_INSTR_BE[XLEN/8-1:0];
          mem_addr_o  = instr_addr_i;
        end

        if (mem_rvalid_i || w_timeout) begin
          w_state_next = ARB_IDLE;
          if (r_owner == ARB_OWNER_DATA) begin
            data_rvalid_o = 1'b1;
            data_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
          end else begin
            instr_rvalid_o = 1'b1;
            instr_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
          end
        end else if (!w_owner_req) begin
          // Owner withdrew (e.g. LSU kill); a late response lands in IDLE and is dropped
          w_state_next = ARB_IDLE;
        end
      end
      default: begin
        w_state_next = ARB_IDLE;
      end
    endcase
  end

  assign arb_busy_o    = w_busy;
  assign arb_timeout_o = w_timeout;

endmodule

`default_nettype wire

// File: tb/tb_miriscv_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_miriscv_mem_arbiter
// Brief   : Directed stimulus with a response scoreboard for miriscv_mem_arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_miriscv_mem_arbiter;

  logic        clk;
  logic        arstn;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        arb_busy;
  logic        arb_timeout;

  int errors = 0;
  int checks = 0;

  // {1 = data port / 0 = instr port, expected rdata}
  logic [32:0] exp_q[$];

  miriscv_mem_arbiter #(
    .XLEN           (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i          (clk),
    .arstn_i        (arstn),
    .instr_req_i    (instr_req),
    .instr_addr_i   (instr_addr),
    .instr_rvalid_o (instr_rvalid),
    .instr_rdata_o  (instr_rdata),
    .data_req_i     (data_req),
    .data_we_i      (data_we),
    .data_be_i      (data_be),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .data_rvalid_o  (data_rvalid),
    .data_rdata_o   (data_rdata),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .mem_be_o       (mem_be),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rvalid_i   (mem_rvalid),
    .mem_rdata_i    (mem_rdata),
    .arb_busy_o     (arb_busy),
    .arb_timeout_o  (arb_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor: every rvalid pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (arstn === 1'b1) begin
      if (instr_rvalid || data_rvalid) begin
        checks++;
        if (instr_rvalid && data_rvalid) begin
          errors++;
          $display("FAIL both_rvalid: instr=%0b data=%0b", instr_rvalid, data_rvalid);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: data_port=%0b rdata=0x%0h expected no response",
                   data_rvalid, data_rvalid ? data_rdata : instr_rdata);
        end else begin
          logic [32:0] e;
          logic [32:0] a;
          e = exp_q.pop_front();
          a = {data_rvalid, data_rvalid ? data_rdata : instr_rdata};
          if (a !== e) begin
            errors++;
            $display("FAIL resp: got port=%0b rdata=0x%0h expected port=%0b rdata=0x%0h",
                     a[32], a[31:0], e[32], e[31:0]);
          end
        end
      end
      if (!instr_rvalid) begin
        checks++;
        if (instr_rdata !== 32'h0) begin
          errors++;
          $display("FAIL instr_rdata_idle: got 0x%0h expected 0x0", instr_rdata);
        end
      end
    end
  end

  logic        rr_is_data [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] rr_rdata   [4] = '{32'h213, 32'h13, 32'h213, 32'h13};

  initial begin
    logic        pending;
    logic [31:0] raddr;
    int          n;

    arstn = 1'b0; instr_req = 1'b0; instr_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_be = '0; data_addr = '0; data_wdata = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset state
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_busy", {31'd0, arb_busy}, 32'd0);
    chk("rst_rvalids", {30'd0, instr_rvalid, data_rvalid}, 32'd0);
    chk("rst_timeout", {31'd0, arb_timeout}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    // Single LSU write, memory answers 3 cycles after the request
    cyc();
    arstn = 1'b1;
    data_req = 1'b1; data_addr = 32'h100; data_we = 1'b1; data_be = 4'hF; data_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("grant_latency", {31'd0, mem_req}, 32'd0);
    cyc();
    @(negedge clk);
    chk("wr_mem_req", {31'd0, mem_req}, 32'd1);
    chk("wr_addr", mem_addr, 32'h100);
    chk("wr_we", {31'd0, mem_we}, 32'd1);
    chk("wr_be", {28'd0, mem_be}, 32'hF);
    chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
    chk("wr_busy", {31'd0, arb_busy}, 32'd1);
    cyc();
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    exp_q.push_back({1'b1, 32'hCAFEF00D});
    @(negedge clk);
    chk("wr_resp_mem_req", {31'd0, mem_req}, 32'd0);
    chk("wr_resp_instr_rvalid", {31'd0, instr_rvalid}, 32'd0);
    cyc();
    data_req = 1'b0; data_we = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk("wr_idle_busy", {31'd0, arb_busy}, 32'd0);

    // Round robin: both held, memory answers one cycle after each request
    cyc();
    arstn = 1'b0;
    cyc();
    arstn = 1'b1;
    instr_req = 1'b1; instr_addr = 32'h0;
    data_req = 1'b1; data_addr = 32'h200; data_we = 1'b0; data_be = 4'hF; data_wdata = '0;
    pending = 1'b0; raddr = '0; n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      cyc();
      mem_rvalid = pending;
      mem_rdata  = pending ? raddr + 32'h13 : 32'h0;
      if (pending) begin
        exp_q.push_back({rr_is_data[n], rr_rdata[n]});
        n++;
      end
      @(negedge clk);
      pending = mem_req;
      raddr   = mem_addr;
    end
    chk("rr_responses", n, 32'd4);
    cyc();
    instr_req = 1'b0; data_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Fetch owns the bus; LSU request arrives mid-transaction and waits
    cyc();
    instr_req = 1'b1; instr_addr = 32'h80;
    cyc();
    data_req = 1'b1; data_addr = 32'h300; data_we = 1'b1; data_be = 4'h3; data_wdata = 32'h55;
    @(negedge clk);
    chk("fetch_addr_1", mem_addr, 32'h80);
    cyc();
    @(negedge clk);
    chk("fetch_addr_2", mem_addr, 32'h80);
    chk("fetch_we", {31'd0, mem_we}, 32'd0);
    chk("fetch_be", {28'd0, mem_be}, 32'hF);
    chk("fetch_wdata", mem_wdata, 32'h0);
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h93;
    exp_q.push_back({1'b0, 32'h93});
    @(negedge clk);
    chk("fetch_addr_3", mem_addr, 32'h80);
    cyc();
    instr_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk("pend_idle_busy", {31'd0, arb_busy}, 32'd0);
    cyc();
    @(negedge clk);
    chk("pend_mem_req", {31'd0, mem_req}, 32'd1);
    chk("pend_addr", mem_addr, 32'h300);
    chk("pend_we", {31'd0, mem_we}, 32'd1);
    chk("pend_be", {28'd0, mem_be}, 32'h3);
    chk("pend_wdata", mem_wdata, 32'h55);
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    exp_q.push_back({1'b1, 32'h77});
    cyc();
    data_req = 1'b0; data_we = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // LSU withdraws after two BUSY cycles; late rvalid collides with a new fetch
    cyc();
    data_req = 1'b1; data_addr = 32'h400; data_we = 1'b0; data_be = 4'hF;
    cyc();
    cyc();
    @(negedge clk);
    chk("kill_pre_req", {31'd0, mem_req}, 32'd1);
    cyc();
    data_req = 1'b0;
    @(negedge clk);
    chk("kill_mem_req", {31'd0, mem_req}, 32'd0);
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
    instr_req = 1'b1; instr_addr = 32'h10;
    @(negedge clk);
    chk("kill_busy", {31'd0, arb_busy}, 32'd0);
    chk("kill_rvalids", {30'd0, instr_rvalid, data_rvalid}, 32'd0);
    cyc();
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk("collide_req", {31'd0, mem_req}, 32'd1);
    chk("collide_addr", mem_addr, 32'h10);
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h23;
    exp_q.push_back({1'b0, 32'h23});
    cyc();
    instr_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset while BUSY drops the transaction; a later rvalid is ignored
    cyc();
    data_req = 1'b1; data_addr = 32'h500;
    cyc();
    arstn = 1'b0;
    @(negedge clk);
    chk("rstbusy_pre", {31'd0, arb_busy}, 32'd1);
    cyc();
    arstn = 1'b1; data_req = 1'b0;
    @(negedge clk);
    chk("rstbusy_req", {31'd0, mem_req}, 32'd0);
    chk("rstbusy_busy", {31'd0, arb_busy}, 32'd0);
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h5A5A;
    @(negedge clk);
    chk("rstbusy_rvalids", {30'd0, instr_rvalid, data_rvalid}, 32'd0);
    cyc();
    mem_rvalid = 1'b0; mem_rdata = '0;

    // Memory never answers
    cyc();
    instr_req = 1'b1; instr_addr = 32'h600;
`ifdef MIRISCV_MEM_ARB_TIMEOUT_EN
    for (int k = 1; k <= 4; k++) begin
      cyc();
      if (k == 4) exp_q.push_back({1'b0, 32'h0});
      @(negedge clk);
      chk("wdog_timeout", {31'd0, arb_timeout}, (k == 4) ? 32'd1 : 32'd0);
    end
    cyc();
    instr_req = 1'b0;
    @(negedge clk);
    chk("wdog_idle", {31'd0, arb_busy}, 32'd0);
`else
    repeat (20) cyc();
    @(negedge clk);
    chk("hang_busy", {31'd0, arb_busy}, 32'd1);
    chk("hang_req", {31'd0, mem_req}, 32'd1);
    chk("hang_timeout", {31'd0, arb_timeout}, 32'd0);
    cyc();
    instr_req = 1'b0;
    cyc();
    @(negedge clk);
    chk("hang_release", {31'd0, arb_busy}, 32'd0);
`endif

    repeat (2) cyc();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
